// File: rtl/syscall_service_unit.sv
`default_nettype none
// ============================================================================
// Module      : syscall_service_unit
// Description : Responds to the MIPS syscall instruction. It stalls the core,
//               decodes the service code in $v0, and then either streams an
//               ASCII rendering of $a0 over a byte valid/ready port or halts
//               the core until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_service_unit #(
    parameter logic [31:0] SYSCALL_WORD = 32'h0000000C,
    parameter bit          NEWLINE_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall,
    output logic        halt,
    output logic        err,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] arg;
    logic [3:0]  code;
    logic [3:0]  cnt;
    logic        err_q;

    logic        det;
    logic        upper_zero;
    logic        svc_int;
    logic        svc_char;
    logic        svc_exit;
    logic        is_char;
    logic        handshake;
    logic        last_byte;
    logic [3:0]  last_idx;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [3:0]  nib;
    logic [7:0]  hex_char;
    logic [7:0]  cur_byte;

    assign det        = (inst == SYSCALL_WORD);
    // Service codes live in v0[3:0]; any bit above that makes the code unknown.
    assign upper_zero = (v0[31:4] == 28'd0);
    assign svc_int    = upper_zero && (v0[3:0] == 4'd1);
    assign svc_char   = upper_zero && (v0[3:0] == 4'd11);
    assign svc_exit   = upper_zero && (v0[3:0] == 4'd10);
    assign is_char    = (code == 4'd11);

    // Index of the final byte of the current print service.
    always_comb begin
        last_idx = 4'd0;
        if (is_char) begin
            last_idx = NEWLINE_EN ? 4'd1 : 4'd0;
        end else begin
            last_idx = NEWLINE_EN ? 4'd8 : 4'd7;
        end
    end

    // Byte generator: hex digits MSB nibble first, or the raw character, then newline.
    always_comb begin
        shamt    = 5'd28 - {cnt[2:0], 2'b00};
        shifted  = arg >> shamt;
        nib      = shifted[3:0];
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
        cur_byte = 8'h0A;
        if (is_char) begin
            if (cnt == 4'd0) begin
                cur_byte = arg[7:0];
            end
        end else if (cnt[3] == 1'b0) begin
            cur_byte = hex_char;
        end
    end

    assign tx_valid  = (state == SEND);
    assign tx_data   = tx_valid ? cur_byte : 8'h00;
    assign handshake = tx_valid && tx_ready;
    assign last_byte = (cnt == last_idx);
    assign halt      = (state == HALT);
    assign err       = err_q;
    // Combinational so the core freezes in the very cycle it fetches syscall;
    // gated by rst so the core is released the moment reset is applied.
    assign stall     = !rst && (((state == IDLE) && det) || (state == SEND) || (state == HALT));

    // State register, argument/code latch, byte counter and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            arg   <= 32'd0;
            code  <= 4'd0;
            cnt   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= (state == IDLE) && det && !(svc_int || svc_char || svc_exit);
            if ((state == IDLE) && det) begin
                arg  <= a0;
                code <= v0[3:0];
                cnt  <= 4'd0;
            end else if (handshake) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (det) begin
                    if (svc_int || svc_char) begin
                        state_next = SEND;
                    end else if (svc_exit) begin
                        state_next = HALT;
                    end else begin
                        state_next = RELEASE;
                    end
                end
            end
            SEND: begin
                if (handshake && last_byte) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_syscall_service_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_syscall_service_unit
// Description : Directed self-checking bench for syscall_service_unit with a
//               tiny PC model that advances by 4 on every unstalled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syscall_service_unit;

    localparam logic [31:0] SYSC = 32'h0000000C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic        halt;
    logic        err;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] pc = 32'd0;
    logic [7:0]  exp_b [9];
    int          n_checks = 0;
    int          n_fails  = 0;

    syscall_service_unit #(
        .SYSCALL_WORD(32'h0000000C),
        .NEWLINE_EN  (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inst    (inst),
        .v0      (v0),
        .a0      (a0),
        .stall   (stall),
        .halt    (halt),
        .err     (err),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Core model: PC advances whenever it is not stalled.
    always @(posedge clk) begin
        if (!stall) pc <= pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one syscall and follow it until the core is released.
    task automatic run_svc(input string tag, input logic [31:0] v, input logic [31:0] a,
                           input bit tog, input int nexp, input int exp_stall, input int exp_err);
        int          nb;
        int          sc;
        int          ec;
        bit          hold;
        bit          released;
        logic [7:0]  held;
        logic [31:0] pc0;
        nb = 0; sc = 0; ec = 0; hold = 0; held = 8'h00; released = 0;
        @(negedge clk);
        pc0 = pc; inst = SYSC; v0 = v; a0 = a; tx_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (err) ec++;
            if (hold) begin
                chk({tag, " hold_valid"}, 32'(tx_valid), 32'd1);
                chk({tag, " hold_data"}, 32'(tx_data), 32'(held));
            end
            if (!stall) begin
                released = 1;
                break;
            end
            sc++;
            if (tx_valid) begin
                if (tx_ready) begin
                    if (nb < 9) chk({tag, " byte"}, 32'(tx_data), 32'(exp_b[nb]));
                    nb++;
                    hold = 0;
                end else begin
                    hold = 1;
                    held = tx_data;
                end
            end
            @(negedge clk);
            if (tog) tx_ready = ~tx_ready;
        end
        chk({tag, " released"}, 32'(released), 32'd1);
        chk({tag, " release_txv"}, 32'(tx_valid), 32'd0);
        chk({tag, " handshakes"}, 32'(nb), 32'(nexp));
        if (exp_stall >= 0) chk({tag, " stall_cycles"}, 32'(sc), 32'(exp_stall));
        @(negedge clk);
        inst = 32'd0; tx_ready = 1'b1;
        #1;
        if (err) ec++;
        chk({tag, " pc_plus4"}, pc, pc0 + 32'd4);
        chk({tag, " err_cycles"}, 32'(ec), 32'(exp_err));
        chk({tag, " idle_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] pc0;
        int          nb;
        rst = 1'b1; inst = 32'd0; v0 = 32'd0; a0 = 32'd0; tx_ready = 1'b1;
        #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst halt", 32'(halt), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst txv", 32'(tx_valid), 32'd0);
        chk("rst txd", 32'(tx_data), 32'd0);
        inst = SYSC;
        #1;
        chk("rst stall_det", 32'(stall), 32'd0);
        inst = 32'd0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Print int, no backpressure: 9 bytes, 10 stalled cycles.
        exp_b = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0A};
        run_svc("int", 32'd1, 32'hDEADBEEF, 1'b0, 9, 10, 0);

        // Print int with alternating tx_ready.
        exp_b = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h66, 8'h0A};
        run_svc("bp", 32'd1, 32'h0000001F, 1'b1, 9, -1, 0);

        // Unknown service codes.
        run_svc("unk5", 32'h00000005, 32'h12345678, 1'b0, 0, 1, 1);
        run_svc("unk11h", 32'h00000011, 32'h12345678, 1'b0, 0, 1, 1);

        // Non-syscall instruction stream.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            r = $urandom;
            if (r == SYSC) r = 32'd0;
            inst = r; v0 = $urandom; a0 = $urandom;
            tx_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rand stall", 32'(stall), 32'd0);
            chk("rand err", 32'(err), 32'd0);
            chk("rand txv", 32'(tx_valid), 32'd0);
        end
        @(negedge clk);
        inst = 32'd0; tx_ready = 1'b1;

        // Print char then exit.
        exp_b = '{8'h41, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_svc("char", 32'd11, 32'h00000041, 1'b0, 2, 3, 0);
        @(negedge clk);
        pc0 = pc; inst = SYSC; v0 = 32'd10; a0 = 32'd0;
        #1;
        chk("exit det_stall", 32'(stall), 32'd1);
        chk("exit det_halt", 32'(halt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inst = SYSC;
            #1;
            chk("exit halt", 32'(halt), 32'd1);
            chk("exit stall", 32'(stall), 32'd1);
            chk("exit txv", 32'(tx_valid), 32'd0);
        end
        chk("exit pc_frozen", pc, pc0);

        // Asynchronous reset out of HALT.
        #1 rst = 1'b1;
        #1;
        chk("arst_halt halt", 32'(halt), 32'd0);
        chk("arst_halt stall", 32'(stall), 32'd0);
        inst = 32'd0;
        @(negedge clk);
        rst = 1'b0;

        // Reset during the 4th byte of a print int.
        @(negedge clk);
        inst = SYSC; v0 = 32'd1; a0 = 32'hCAFEF00D; tx_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (tx_valid && nb == 3) break;
            if (tx_valid && tx_ready) nb++;
            @(negedge clk);
        end
        chk("mid 4th_valid", 32'(tx_valid), 32'd1);
        chk("mid 4th_byte", 32'(tx_data), 32'h65);
        #1 rst = 1'b1;
        #1;
        chk("mid txv", 32'(tx_valid), 32'd0);
        chk("mid stall", 32'(stall), 32'd0);
        chk("mid halt", 32'(halt), 32'd0);
        chk("mid txd", 32'(tx_data), 32'd0);
        inst = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid idle_txv", 32'(tx_valid), 32'd0);
        exp_b = '{8'h5A, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_svc("post_rst char", 32'd11, 32'h0000005A, 1'b0, 2, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/syscall_service_unit.md
Name: syscall_service_unit

Overview:
- Hardware responder to the `syscall` instruction issued by MIPS_Core.
- When the core's current instruction is `syscall` (32'h0000000C), the block stalls the core and reads the service code in $v0. It then either streams an ASCII rendering of $a0 on a byte valid/ready output or halts the core permanently.
- Sits beside MIPS_Core at top level. It replaces the bench-side syscall detection so programs can print and exit on silicon.

Parameters:
- SYSCALL_WORD, 32'h0000000C, instruction encoding recognised as syscall.
- NEWLINE_EN, 1, when 1 a 0x0A byte follows every print service.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inst  input  32  current instruction from MIPS_Core.
- v0  input  32  register $v0, service code.
- a0  input  32  register $a0, service argument.
- stall  output  1  holds MIPS_Core PC and register writes when 1.
- halt  output  1  sticky; program exited.
- err  output  1  one-cycle pulse on an unknown service code.
- tx_data  output  8  output byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  sink accepts the byte when tx_valid & tx_ready.

Behaviour:
- Reset (async, rst=1): state=IDLE, halt=0, err=0, tx_valid=0, tx_data=0, internal byte counter=0, latched arg=0. stall is combinational and evaluates to 0 in IDLE with rst=1.
- det = (inst == SYSCALL_WORD).
- stall = (state==IDLE & det) | state==SEND | state==HALT. It is 0 in RELEASE. stall is combinational so a single-cycle core freezes in the same cycle the syscall is fetched.
- Services, from v0 latched at detect:
  - v0=1, print int as hex: 8 ASCII chars of a0, MSB nibble first. Nibble 0-9 maps to 0x30+n; nibble 10-15 maps to 0x61+(n-10). Then 0x0A if NEWLINE_EN.
  - v0=11, print char: one byte, a0[7:0], then 0x0A if NEWLINE_EN.
  - v0=10, exit: no bytes.
  - Any other code: err pulses 1 cycle, no bytes.
- States:
  - IDLE: on det at the clock edge, latch a0 into arg and v0[3:0] into code, and clear the counter.
    - code 1 or 11: go to SEND.
    - code 10: go to HALT.
    - otherwise: err=1 for that next cycle, go to RELEASE.
  - SEND: tx_valid=1 and tx_data = byte[counter].
    - On handshake (tx_valid & tx_ready), counter+1.
    - On handshake of the last byte, go to RELEASE. Last index = 7 or 8 for print int (8 or 9 bytes); 0 or 1 for print char (1 or 2 bytes).
    - With tx_ready=0, tx_data and tx_valid hold stable indefinitely. tx_valid never drops before the handshake.
  - RELEASE: stall=0 and tx_valid=0 for exactly one cycle, so the core retires the syscall (PC+4). det is ignored in this state, preventing re-trigger on the same syscall. Next state IDLE.
  - HALT: stall=1 and halt=1 forever; exit only via rst.
- Back-to-back syscalls: a syscall at PC+4 is detected in the IDLE cycle following RELEASE, giving minimum 1 free cycle between services.
- Latency, print int with tx_ready tied 1: detect edge, then 9 byte cycles (NEWLINE_EN=1), then 1 RELEASE cycle. The core is stalled for 10 cycles including the detect cycle.
- Reset mid-SEND: output is abandoned immediately and tx_valid=0. No partial-byte state survives.
- Only v0[3:0] is compared after confirming v0[31:4]==0. A nonzero upper part counts as unknown and raises err.

Test Plan:
- Print int: a0=32'hDEADBEEF, v0=1, tx_ready=1. Required bytes are 64 65 61 64 62 65 65 66 0A. stall=1 for 10 cycles, then PC advances by 4 once.
- Backpressure: a0=32'h0000001F, v0=1, tx_ready toggled 1/0 every cycle. Bytes are 30 30 30 30 30 30 31 66 0A, with tx_data stable and tx_valid held while tx_ready=0. Exactly 9 handshakes occur.
- Print char then exit: v0=11, a0=0x41, followed by a syscall with v0=10. Output is 41 0A, then halt=1 and stall=1 sticky, with PC frozen at the second syscall.
- Unknown code: v0=32'h00000005. err high for exactly 1 cycle, no tx_valid, core resumes after 2 stalled/release cycles. The v0=32'h00000011 case also raises err.
- Reset mid-operation: assert rst during the 4th byte of a print int. tx_valid, stall and halt drop asynchronously without waiting for clk. After deassert the block is IDLE and a new v0=11 syscall prints correctly.
- Non-syscall stream: 1000 random instructions excluding 0x0000000C. stall, err and tx_valid remain 0 throughout.
